// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Multi-cycle fetch / decode / control sequencer for a small
//               addi + bne datapath. Fetches over a req/valid handshake,
//               holds the instruction for one EXEC cycle while driving the
//               register-file and ALU controls, then updates pc and retired.
//   Ports     : clk, rst (async, active-low)
//               imem_req/imem_addr/imem_valid/imem_rdata : instruction fetch
//               EQ                                      : datapath compare flag
//               AD1/AD2/AD3/WE3/ALUsrc/ALUctrl/ImmOp    : datapath controls
//               pc, retired, halted                     : status
//   Options   : define FETCH_CTRL_TRAP_EN to halt on undecoded opcodes
//               (default: undecoded opcodes retire as NOPs).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int                    DATA_WIDTH          = 32,
    parameter int                    REG_FILE_ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC            = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           imem_req,
    output logic [DATA_WIDTH-1:0]          imem_addr,
    input  logic                           imem_valid,
    input  logic [DATA_WIDTH-1:0]          imem_rdata,
    input  logic                           EQ,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
    output logic                           WE3,
    output logic                           ALUsrc,
    output logic                           ALUctrl,
    output logic [DATA_WIDTH-1:0]          ImmOp,
    output logic [DATA_WIDTH-1:0]          pc,
    output logic [DATA_WIDTH-1:0]          retired,
    output logic                           halted
);

    localparam logic [6:0] C_OP_ADDI = 7'b0010011;
    localparam logic [6:0] C_OP_BNE  = 7'b1100011;
    localparam logic [2:0] C_F3_ADDI = 3'b000;
    localparam logic [2:0] C_F3_BNE  = 3'b001;

`ifdef FETCH_CTRL_TRAP_EN
    localparam int                C_ST_W     = 2;
    localparam logic [C_ST_W-1:0] C_ST_FETCH = 2'd0;
    localparam logic [C_ST_W-1:0] C_ST_EXEC  = 2'd1;
    localparam logic [C_ST_W-1:0] C_ST_HALT  = 2'd2;
`else
    localparam int                C_ST_W     = 1;
    localparam logic [C_ST_W-1:0] C_ST_FETCH = 1'b0;
    localparam logic [C_ST_W-1:0] C_ST_EXEC  = 1'b1;
`endif

    logic [C_ST_W-1:0]              r_state;
    logic [C_ST_W-1:0]              w_state_nxt;
    // Low during reset and for the first cycle after it, so the fetch
    // request only rises once the sequencer has seen a clock out of reset.
    logic                           r_run;
    logic [DATA_WIDTH-1:0]          r_pc;
    logic [DATA_WIDTH-1:0]          r_ir;
    logic [DATA_WIDTH-1:0]          r_retired;

    logic [6:0]                     w_opcode;
    logic [2:0]                     w_funct3;
    logic [REG_FILE_ADDR_WIDTH-1:0] w_rd;
    logic [REG_FILE_ADDR_WIDTH-1:0] w_rs1;
    logic [REG_FILE_ADDR_WIDTH-1:0] w_rs2;
    logic                           w_is_addi;
    logic                           w_is_bne;
    logic [DATA_WIDTH-1:0]          w_imm_i;
    logic [DATA_WIDTH-1:0]          w_imm_b;
    logic [DATA_WIDTH-1:0]          w_pc_nxt;
    logic                           w_xfer;
    logic                           w_retire;

    // ---------------------------------------------------------------- decode
    assign w_opcode  = r_ir[6:0];
    assign w_funct3  = r_ir[14:12];
    assign w_rd      = REG_FILE_ADDR_WIDTH'(r_ir[11:7]);
    assign w_rs1     = REG_FILE_ADDR_WIDTH'(r_ir[19:15]);
    assign w_rs2     = REG_FILE_ADDR_WIDTH'(r_ir[24:20]);
    assign w_is_addi = (w_opcode == C_OP_ADDI) && (w_funct3 == C_F3_ADDI);
    assign w_is_bne  = (w_opcode == C_OP_BNE)  && (w_funct3 == C_F3_BNE);
    assign w_imm_i   = {{(DATA_WIDTH-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_b   = {{(DATA_WIDTH-13){r_ir[31]}}, r_ir[31], r_ir[7],
                        r_ir[30:25], r_ir[11:8], 1'b0};

    // Branch taken when the operands differ; everything else falls through.
    assign w_pc_nxt  = (w_is_bne && !EQ) ? (r_pc + w_imm_b)
                                         : (r_pc + DATA_WIDTH'(4));

    assign w_xfer    = (r_state == C_ST_FETCH) && r_run && imem_valid;

`ifdef FETCH_CTRL_TRAP_EN
    // A trapping instruction neither advances pc nor counts as retired.
    assign w_retire  = (r_state == C_ST_EXEC) && (w_is_addi || w_is_bne);
`else
    assign w_retire  = (r_state == C_ST_EXEC);
`endif

    // -------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= C_ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_FETCH: begin
                if (w_xfer) begin
                    w_state_nxt = C_ST_EXEC;
                end
            end
            C_ST_EXEC: begin
`ifdef FETCH_CTRL_TRAP_EN
                if (w_is_addi || w_is_bne) begin
                    w_state_nxt = C_ST_FETCH;
                end else begin
                    w_state_nxt = C_ST_HALT;
                end
`else
                w_state_nxt = C_ST_FETCH;
`endif
            end
`ifdef FETCH_CTRL_TRAP_EN
            C_ST_HALT: begin
                w_state_nxt = C_ST_HALT;
            end
`endif
            default: begin
                w_state_nxt = C_ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------ pc / ir / retired regs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run     <= 1'b0;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_xfer) begin
                r_ir <= imem_rdata;
            end
            if (w_retire) begin
                r_pc      <= w_pc_nxt;
                r_retired <= r_retired + DATA_WIDTH'(1);
            end
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        imem_req = 1'b0;
        AD1      = '0;
        AD2      = '0;
        AD3      = '0;
        WE3      = 1'b0;
        ALUsrc   = 1'b0;
        ALUctrl  = 1'b0;
        ImmOp    = '0;
        halted   = 1'b0;
        case (r_state)
            C_ST_FETCH: begin
                imem_req = r_run;
            end
            C_ST_EXEC: begin
                if (w_is_addi) begin
                    AD1    = w_rs1;
                    AD3    = w_rd;
                    WE3    = (w_rd != '0);
                    ALUsrc = 1'b1;
                    ImmOp  = w_imm_i;
                end else if (w_is_bne) begin
                    AD1     = w_rs1;
                    AD2     = w_rs2;
                    ALUctrl = 1'b1;
                    ImmOp   = w_imm_b;
                end
            end
`ifdef FETCH_CTRL_TRAP_EN
            C_ST_HALT: begin
                halted = 1'b1;
            end
`endif
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign retired   = r_retired;

endmodule
`default_nettype wire
